// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level sequencer for the 2x2 sliding-tile puzzle.
// Picks a preset board, starts and restarts games, gates move pulses
// to the play controller and counts legal moves from the tracked blank.
//
// Ports:
//   clk_d        system clock, rising edge
//   reset        asynchronous active-low reset
//   act[3:0]     key pulses: [0]=up [1]=right [2]=down [3]=left
//   btn_confirm  confirm pulse
//   btn_restart  restart pulse
//   btn_back     back pulse
//   win_flag     registered win indication from the play controller
//   game_status  00 CHOSE_BOARD, 01 GAMING, 10 GAME_INITIAL, 11 WINNED
//   origin_board selected preset board
//   board_idx    selected preset index
//   restart      one-cycle strobe into the play controller
//   act_out      registered, gated copy of act
//   move_count   legal moves this attempt, saturating at 999
module game_flow_ctrl (
  input  logic        clk_d,
  input  logic        reset,
  input  logic [3:0]  act,
  input  logic        btn_confirm,
  input  logic        btn_restart,
  input  logic        btn_back,
  input  logic        win_flag,
  output logic [1:0]  game_status,
  output logic [11:0] origin_board,
  output logic [1:0]  board_idx,
  output logic        restart,
  output logic [3:0]  act_out,
  output logic [9:0]  move_count
);

  localparam int unsigned BOARD_W = 12;
  localparam int unsigned CNT_W   = 10;

  localparam logic [BOARD_W-1:0] BOARD0 = 12'b001_011_100_000;
  localparam logic [BOARD_W-1:0] BOARD1 = 12'b011_000_100_001;
  localparam logic [BOARD_W-1:0] BOARD2 = 12'b000_001_100_010;
  localparam logic [BOARD_W-1:0] BOARD3 = 12'b010_000_100_001;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(999);

  // Blank position encoding
  localparam logic [1:0] POS_LU = 2'd0;
  localparam logic [1:0] POS_RU = 2'd1;
  localparam logic [1:0] POS_LD = 2'd2;
  localparam logic [1:0] POS_RD = 2'd3;

  typedef enum logic [1:0] {
    ST_CHOSE_BOARD  = 2'b00,
    ST_GAMING       = 2'b01,
    ST_GAME_INITIAL = 2'b10,
    ST_WINNED       = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [BOARD_W-1:0] origin_q, origin_d;
  logic               restart_q, restart_d;
  logic [3:0]         act_out_q, act_out_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         blank_q, blank_d;
  logic [1:0]         guard_q, guard_d;

  // Preset lookup
  function automatic logic [BOARD_W-1:0] preset(input logic [1:0] idx);
    logic [BOARD_W-1:0] b;
    case (idx)
      2'd0:    b = BOARD0;
      2'd1:    b = BOARD1;
      2'd2:    b = BOARD2;
      default: b = BOARD3;
    endcase
    return b;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk_d or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_CHOSE_BOARD;
      idx_q     <= 2'd0;
      origin_q  <= BOARD0;
      restart_q <= 1'b0;
      act_out_q <= 4'd0;
      count_q   <= '0;
      blank_q   <= POS_LD;
      guard_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      origin_q  <= origin_d;
      restart_q <= restart_d;
      act_out_q <= act_out_d;
      count_q   <= count_d;
      blank_q   <= blank_d;
      guard_q   <= guard_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CHOSE_BOARD:  if (btn_confirm) state_d = ST_GAME_INITIAL;
      ST_GAME_INITIAL: state_d = ST_GAMING;
      ST_GAMING: begin
        if (btn_back)                             state_d = ST_CHOSE_BOARD;
        else if (btn_restart)                     state_d = ST_GAMING;
        else if (win_flag && (guard_q == 2'd0))   state_d = ST_WINNED;
      end
      ST_WINNED: begin
        if (btn_confirm || btn_back) state_d = ST_CHOSE_BOARD;
        else if (btn_restart)        state_d = ST_GAMING;
      end
      default: state_d = ST_CHOSE_BOARD;
    endcase
  end

  // Next values for the registered outputs and move tracking
  always_comb begin
    logic       do_restart;
    logic       legal;
    logic [1:0] new_blank;

    idx_d      = idx_q;
    restart_d  = 1'b0;
    act_out_d  = 4'd0;
    count_d    = count_q;
    blank_d    = blank_q;
    guard_d    = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
    do_restart = 1'b0;
    legal      = 1'b0;
    new_blank  = blank_q;

    // Blank moves toward the pressed direction; first listed key wins
    case (blank_q)
      POS_LU: begin
        if (act[1])      begin legal = 1'b1; new_blank = POS_RU; end
        else if (act[2]) begin legal = 1'b1; new_blank = POS_LD; end
      end
      POS_RU: begin
        if (act[3])      begin legal = 1'b1; new_blank = POS_LU; end
        else if (act[2]) begin legal = 1'b1; new_blank = POS_RD; end
      end
      POS_LD: begin
        if (act[0])      begin legal = 1'b1; new_blank = POS_LU; end
        else if (act[1]) begin legal = 1'b1; new_blank = POS_RD; end
      end
      default: begin
        if (act[0])      begin legal = 1'b1; new_blank = POS_RU; end
        else if (act[3]) begin legal = 1'b1; new_blank = POS_LD; end
      end
    endcase

    case (state_q)
      ST_CHOSE_BOARD: begin
        if (!btn_confirm) begin
          if (act[0])      idx_d = idx_q - 2'd1;
          else if (act[2]) idx_d = idx_q + 2'd1;
        end
      end
      ST_GAME_INITIAL: do_restart = 1'b1;
      ST_GAMING: begin
        if (btn_back) begin
          // hold count, drop act
        end else if (btn_restart) begin
          do_restart = 1'b1;
        end else if (win_flag && (guard_q == 2'd0)) begin
          // win takes the cycle
        end else if (!restart_q) begin
          // first GAMING cycle of an attempt drops act
          act_out_d = act;
          if (legal) begin
            blank_d = new_blank;
            if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_WINNED: begin
        if (!(btn_confirm || btn_back) && btn_restart) do_restart = 1'b1;
      end
      default: ;
    endcase

    // Any restart: fresh attempt, win guard masks stale win_flag for 2 cycles
    if (do_restart) begin
      restart_d = 1'b1;
      count_d   = '0;
      blank_d   = POS_LD;
      guard_d   = 2'd2;
    end
  end

  assign origin_d = preset(idx_d);

  assign game_status  = state_q;
  assign board_idx    = idx_q;
  assign origin_board = origin_q;
  assign restart      = restart_q;
  assign act_out      = act_out_q;
  assign move_count   = count_q;

endmodule
